// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared SimpleRISC definitions: opcodes, instruction field ranges and the
// hazard sequencer state encoding.
package pipeline_hazard_ctrl_pkg;

    // Opcodes (inst[31:27]); ALU ops occupy 0..12 (add .. asr)
    localparam logic [4:0] OpcAdd  = 5'd0;
    localparam logic [4:0] OpcAsr  = 5'd12;
    localparam logic [4:0] OpcNop  = 5'd13;
    localparam logic [4:0] OpcLd   = 5'd14;
    localparam logic [4:0] OpcSt   = 5'd15;
    localparam logic [4:0] OpcBeq  = 5'd16;
    localparam logic [4:0] OpcBgt  = 5'd17;
    localparam logic [4:0] OpcB    = 5'd18;
    localparam logic [4:0] OpcCall = 5'd19;
    localparam logic [4:0] OpcRet  = 5'd20;

    // Instruction field bit ranges
    localparam int unsigned OpcHi = 31;
    localparam int unsigned OpcLo = 27;
    localparam int unsigned ImmB  = 26;
    localparam int unsigned RdHi  = 25;
    localparam int unsigned RdLo  = 22;
    localparam int unsigned Rs1Hi = 21;
    localparam int unsigned Rs1Lo = 18;
    localparam int unsigned Rs2Hi = 17;
    localparam int unsigned Rs2Lo = 14;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } hazard_state_e;

    function automatic logic [4:0] get_opc(input logic [31:0] inst);
        return inst[OpcHi:OpcLo];
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the hazard sequencer and the pipeline/fetch unit.
// HAZARD_STATS_EN adds the saturating stall/flush statistics counters.
interface pipeline_hazard_ctrl_if
`ifdef HAZARD_STATS_EN
    #(parameter int unsigned STAT_W = 16)
`endif
    ;
    logic [31:0] of_inst;
    logic        of_valid;
    logic        ex_is_ld;
    logic [3:0]  ex_rd;
    logic        br_taken_ex;
    logic        mem_busy;
    logic        stop;
    logic        br_redirect;
    logic        if_of_hold;
    logic        of_ex_bubble;
    logic        freeze;
    logic        flush;
    logic        halted;
    logic        mem_err;
`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt;
    logic [STAT_W-1:0] flush_cnt;
`endif

    // Pipeline side: drives status, consumes controls
    modport master (
        output of_inst, of_valid, ex_is_ld, ex_rd, br_taken_ex, mem_busy,
        input  stop, br_redirect, if_of_hold, of_ex_bubble, freeze, flush, halted, mem_err
`ifdef HAZARD_STATS_EN
        , input stall_cnt, flush_cnt
`endif
    );

    // Sequencer side
    modport slave (
        input  of_inst, of_valid, ex_is_ld, ex_rd, br_taken_ex, mem_busy,
        output stop, br_redirect, if_of_hold, of_ex_bubble, freeze, flush, halted, mem_err
`ifdef HAZARD_STATS_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Operand-source decode for the OF-stage instruction and load-use compare
// against the EX-stage load destination.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] opc,
    input  logic       imm,
    input  logic [3:0] rd,
    input  logic [3:0] rs1,
    input  logic [3:0] rs2,
    input  logic       of_valid,
    input  logic       ex_is_ld,
    input  logic [3:0] ex_rd,
    output logic       load_use
);

    logic is_alu;
    logic uses_rs1;
    logic uses_rs2;
    logic uses_rd;

    // Which register fields are real sources; st reads its data from rd
    always_comb begin
        is_alu   = (opc <= OpcAsr);
        uses_rs1 = is_alu | (opc == OpcLd) | (opc == OpcSt);
        uses_rs2 = is_alu & ~imm;
        uses_rd  = (opc == OpcSt);
        load_use = of_valid & ex_is_ld &
                   ((uses_rs1 & (rs1 == ex_rd)) |
                    (uses_rs2 & (rs2 == ex_rd)) |
                    (uses_rd  & (rd  == ex_rd)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage SimpleRISC pipeline: memory-wait FSM
// with watchdog, branch flush, load-use bubble and HALT.
// Optional feature macro: HAZARD_STATS_EN (stall_cnt / flush_cnt counters).
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter logic [4:0]  HALT_OPCODE = 5'b11111,
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef HAZARD_STATS_EN
    , parameter int unsigned STAT_W = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    hazard_state_e state_q, state_d;
    logic [7:0]    wdog_q, wdog_d;
    logic          mem_err_q, mem_err_d;
    logic          load_use;
    logic          run_eval;
    logic          halt_hit;
    logic          stop, br_redirect, if_of_hold, of_ex_bubble, freeze, flush;
    logic          unused_imm_bits;

    assign unused_imm_bits = ^bus.of_inst[Rs2Lo-1:0];

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .opc      (get_opc(bus.of_inst)),
        .imm      (bus.of_inst[ImmB]),
        .rd       (bus.of_inst[RdHi:RdLo]),
        .rs1      (bus.of_inst[Rs1Hi:Rs1Lo]),
        .rs2      (bus.of_inst[Rs2Hi:Rs2Lo]),
        .of_valid (bus.of_valid),
        .ex_is_ld (bus.ex_is_ld),
        .ex_rd    (bus.ex_rd),
        .load_use (load_use)
    );

    assign halt_hit = bus.of_valid & (get_opc(bus.of_inst) == HALT_OPCODE);

    // Next-state, watchdog and prioritised control outputs
    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        mem_err_d    = mem_err_q;
        run_eval     = 1'b0;
        stop         = 1'b0;
        br_redirect  = 1'b0;
        if_of_hold   = 1'b0;
        of_ex_bubble = 1'b0;
        freeze       = 1'b0;
        flush        = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.mem_busy) begin
                    freeze     = 1'b1;
                    stop       = 1'b1;
                    if_of_hold = 1'b1;
                    wdog_d     = 8'd1;
                    state_d    = StMemWait;
                end else begin
                    run_eval = 1'b1;
                end
            end
            StMemWait: begin
                if (bus.mem_busy) begin
                    freeze     = 1'b1;
                    stop       = 1'b1;
                    if_of_hold = 1'b1;
                    if (wdog_q == 8'(MEM_TIMEOUT)) begin
                        mem_err_d = 1'b1;
                        state_d   = StHalt;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
                end else begin
                    // Memory released: behave as RUN in this very cycle
                    run_eval = 1'b1;
                    wdog_d   = 8'd0;
                    state_d  = StRun;
                end
            end
            StHalt: begin
                stop         = 1'b1;
                if_of_hold   = 1'b1;
                of_ex_bubble = 1'b1;
            end
            default: state_d = StRun;
        endcase

        if (run_eval) begin
            if (bus.br_taken_ex) begin
                br_redirect = 1'b1;
                flush       = 1'b1;
            end else if (load_use) begin
                stop         = 1'b1;
                if_of_hold   = 1'b1;
                of_ex_bubble = 1'b1;
            end else if (halt_hit) begin
                stop         = 1'b1;
                if_of_hold   = 1'b1;
                of_ex_bubble = 1'b1;
                state_d      = StHalt;
            end
        end
    end

    // State, watchdog and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            wdog_q    <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign bus.stop         = stop;
    assign bus.br_redirect  = br_redirect;
    assign bus.if_of_hold   = if_of_hold;
    assign bus.of_ex_bubble = of_ex_bubble;
    assign bus.freeze       = freeze;
    assign bus.flush        = flush;
    assign bus.halted       = (state_q == StHalt);
    assign bus.mem_err      = mem_err_q;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q;
    logic [STAT_W-1:0] flush_cnt_q;

    // Saturating statistics; HALT stop cycles are not stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stop && (state_q != StHalt) && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: each step pushes the expected
// control vector to a scoreboard queue, which is popped and compared mid-cycle.
module tb_pipeline_hazard_ctrl;

    // Expected vector: {stop, br_redirect, if_of_hold, of_ex_bubble,
    //                   freeze, flush, halted, mem_err}
    localparam logic [7:0] E_NONE  = 8'b0000_0000;
    localparam logic [7:0] E_LU    = 8'b1011_0000;
    localparam logic [7:0] E_BR    = 8'b0100_0100;
    localparam logic [7:0] E_MEM   = 8'b1010_1000;
    localparam logic [7:0] E_HALT  = 8'b1011_0010;
    localparam logic [7:0] E_ERR   = 8'b1011_0011;

    localparam logic [4:0] ADD = 5'd0;
    localparam logic [4:0] NOP = 5'd13;
    localparam logic [4:0] LD  = 5'd14;
    localparam logic [4:0] ST  = 5'd15;
    localparam logic [4:0] BEQ = 5'd16;
    localparam logic [4:0] HLT = 5'b11111;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(
        .HALT_OPCODE (5'b11111),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] enc(input logic [4:0] opc, input logic i,
                                        input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [3:0] rs2, input logic [13:0] low);
        return {opc, i, rd, rs1, rs2, low};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic v, input logic ld,
                         input logic [3:0] rd, input logic br, input logic busy);
        bus.of_inst     = inst;
        bus.of_valid    = v;
        bus.ex_is_ld    = ld;
        bus.ex_rd       = rd;
        bus.br_taken_ex = br;
        bus.mem_busy    = busy;
    endtask

    // One cycle: drive, queue expectation, compare at negedge, advance past posedge
    task automatic step(input string tag, input logic [31:0] inst, input logic v,
                        input logic ld, input logic [3:0] rd, input logic br,
                        input logic busy, input logic [7:0] exp);
        logic [7:0] got;
        drive(inst, v, ld, rd, br, busy);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        got = {bus.stop, bus.br_redirect, bus.if_of_hold, bus.of_ex_bubble,
               bus.freeze, bus.flush, bus.halted, bus.mem_err};
        check_eq(tag_q.pop_front(), {24'd0, got}, {24'd0, exp_q.pop_front()});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] nop_i, add_r3r2, add_imm, add_r1r3, st_r3, beq_i, halt_i, ld_i;

    initial begin
        nop_i    = enc(NOP, 1'b0, 4'd0, 4'd0, 4'd0, 14'd0);
        add_r3r2 = enc(ADD, 1'b0, 4'd5, 4'd3, 4'd2, 14'd0);
        add_imm  = enc(ADD, 1'b1, 4'd5, 4'd1, 4'd3, 14'd0);
        add_r1r3 = enc(ADD, 1'b0, 4'd5, 4'd1, 4'd3, 14'd0);
        st_r3    = enc(ST,  1'b1, 4'd3, 4'd1, 4'd0, 14'd4);
        beq_i    = enc(BEQ, 1'b0, 4'd3, 4'd3, 4'd3, 14'd0);
        halt_i   = enc(HLT, 1'b0, 4'd0, 4'd0, 4'd0, 14'd0);
        ld_i     = enc(LD,  1'b1, 4'd4, 4'd3, 4'd0, 14'd8);

        do_reset();
        check_eq("reset_halted", {31'd0, bus.halted}, 32'd0);
        check_eq("reset_mem_err", {31'd0, bus.mem_err}, 32'd0);
        step("reset_idle", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_NONE);

        // Load-use on rs1: single bubble, then the ld has moved on
        step("lu_rs1", add_r3r2, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, E_LU);
        step("lu_rs1_after", add_r3r2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_NONE);
        step("lu_imm_no_rs2", add_imm, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, E_NONE);
        step("lu_rs2", add_r1r3, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, E_LU);
        step("lu_st_rd", st_r3, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, E_LU);
        step("lu_ld_rs1", ld_i, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, E_LU);
        step("lu_branch_none", beq_i, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, E_NONE);
        step("lu_invalid", add_r3r2, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, E_NONE);
        step("lu_not_ld", add_r3r2, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, E_NONE);

        // Branch beats load-use
        step("br_over_lu", add_r3r2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, E_BR);

        // Memory wait with a branch held in EX
        for (int c = 0; c < 5; c++) begin
            step("memwait_br", nop_i, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, E_MEM);
        end
        step("memwait_release_br", nop_i, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, E_BR);
        step("memwait_back_run", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_NONE);

        // Release with load-use pending: evaluated as RUN that cycle
        step("memwait2", add_r3r2, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, E_MEM);
        step("memwait2_lu", add_r3r2, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, E_LU);
        step("memwait2_done", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_NONE);

        // Watchdog: busy for MEM_TIMEOUT+1 cycles
        for (int c = 0; c < 17; c++) begin
            step("wdog_wait", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, E_MEM);
        end
        step("wdog_err", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_ERR);
        step("wdog_err_br", nop_i, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, E_ERR);
        do_reset();
        step("wdog_rst_clear", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_NONE);

        // One short of the timeout: no error
        for (int c = 0; c < 16; c++) begin
            step("wdog_short", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, E_MEM);
        end
        step("wdog_short_done", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_NONE);

        // HALT opcode
        step("halt_enter", halt_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_LU);
        step("halt_state", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_HALT);
        step("halt_br_blocked", nop_i, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, E_HALT);
        step("halt_busy", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, E_HALT);
        do_reset();
        step("halt_invalid", halt_i, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, E_NONE);
        step("halt_invalid_next", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_NONE);

        // Reset in the middle of a memory wait leaves no residue
        step("mid_wait", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, E_MEM);
        step("mid_wait2", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, E_MEM);
        do_reset();
        step("mid_wait_rst", nop_i, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, E_NONE);

        check_eq("sb_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
